// File: rtl/ctrl_fsm_seq.sv
// Sequencing controller: walks a one-hot strobe across the enabled channels, LEN+1 cycles each.
// Optional CTRL_FSM_SEQ_REPEAT_EN adds REPEAT / PASS_CNT for back-to-back passes.
module ctrl_fsm_seq #(
  parameter int NCH   = 7,
  parameter int CNT_W = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic [NCH-1:0]   CMD,
  input  logic [CNT_W-1:0] LEN,
  input  logic             STALL,
  input  logic             ABORT,
`ifdef CTRL_FSM_SEQ_REPEAT_EN
  input  logic             REPEAT,
  output logic [7:0]       PASS_CNT,
`endif
  output logic [NCH-1:0]   OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORTED,
  output logic             ERR,
  output logic [1:0]       STATE
);

  localparam int PTR_W = $clog2(NCH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg;
  logic [NCH-1:0]   mask_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] timer_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [NCH-1:0]   out_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             aborted_reg;
  logic             err_reg;

  logic [NCH-1:0]   above_mask;
  logic [PTR_W-1:0] first_cmd;
  logic [PTR_W-1:0] next_ptr;
  logic             next_found;

  // Enabled channels strictly above the current pointer.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_above
      assign above_mask[gi] = mask_reg[gi] && (PTR_W'(gi) > ptr_reg);
    end
  endgenerate

  always_comb begin
    first_cmd  = '0;
    next_ptr   = '0;
    next_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (CMD[i]) first_cmd = PTR_W'(i);
      if (above_mask[i]) begin
        next_ptr   = PTR_W'(i);
        next_found = 1'b1;
      end
    end
  end

`ifdef CTRL_FSM_SEQ_REPEAT_EN
  logic [PTR_W-1:0] first_mask;
  logic [7:0]       pass_cnt_reg;
  logic [7:0]       pass_cnt_next;

  always_comb begin
    first_mask = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_reg[i]) first_mask = PTR_W'(i);
    end
    pass_cnt_next = (pass_cnt_reg == 8'hFF) ? pass_cnt_reg : pass_cnt_reg + 8'd1;
  end

  assign PASS_CNT = pass_cnt_reg;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg   <= S_IDLE;
      mask_reg    <= '0;
      len_reg     <= '0;
      timer_reg   <= '0;
      ptr_reg     <= '0;
      out_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      err_reg     <= 1'b0;
`ifdef CTRL_FSM_SEQ_REPEAT_EN
      pass_cnt_reg <= '0;
`endif
    end else begin
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      err_reg     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (START) begin
            if (CMD != '0) begin
              mask_reg  <= CMD;
              len_reg   <= LEN;
              timer_reg <= LEN;
              ptr_reg   <= first_cmd;
              out_reg   <= ONE_HOT0 << first_cmd;
              busy_reg  <= 1'b1;
              state_reg <= S_RUN;
`ifdef CTRL_FSM_SEQ_REPEAT_EN
              pass_cnt_reg <= '0;
`endif
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Abort wins over both stall and timer expiry.
          if (ABORT) begin
            state_reg   <= S_IDLE;
            out_reg     <= '0;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else if (!STALL) begin
            if (timer_reg != '0) begin
              timer_reg <= timer_reg - CNT_W'(1);
            end else if (next_found) begin
              ptr_reg   <= next_ptr;
              timer_reg <= len_reg;
              out_reg   <= ONE_HOT0 << next_ptr;
            end else begin
`ifdef CTRL_FSM_SEQ_REPEAT_EN
              pass_cnt_reg <= pass_cnt_next;
              if (REPEAT) begin
                ptr_reg   <= first_mask;
                timer_reg <= len_reg;
                out_reg   <= ONE_HOT0 << first_mask;
              end else begin
                state_reg <= S_DONE;
                out_reg   <= '0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
`else
              state_reg <= S_DONE;
              out_reg   <= '0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
`endif
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          out_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign OUT     = out_reg;
  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign ABORTED = aborted_reg;
  assign ERR     = err_reg;
  assign STATE   = state_reg;

endmodule

// File: tb/tb_ctrl_fsm_seq.sv
// Directed bench for ctrl_fsm_seq: per-cycle expected outputs queued when stimulus is driven.
module tb_ctrl_fsm_seq;

  logic       CLOCK = 1'b0;
  logic       RESET, START, STALL, ABORT;
  logic [6:0] CMD;
  logic [7:0] LEN;
  logic [6:0] OUT;
  logic       BUSY, DONE, ABORTED, ERR;
  logic [1:0] STATE;
`ifdef CTRL_FSM_SEQ_REPEAT_EN
  logic       REPEAT;
  logic [7:0] PASS_CNT;
`endif

  ctrl_fsm_seq #(.NCH(7), .CNT_W(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .CMD(CMD), .LEN(LEN),
    .STALL(STALL), .ABORT(ABORT),
`ifdef CTRL_FSM_SEQ_REPEAT_EN
    .REPEAT(REPEAT), .PASS_CNT(PASS_CNT),
`endif
    .OUT(OUT), .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED), .ERR(ERR), .STATE(STATE)
  );

  always #5 CLOCK = ~CLOCK;

  // Expected {OUT, BUSY, DONE, ABORTED, ERR, STATE} for each successive cycle.
  logic [12:0] sb[$];
  string       tags[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic push(input string tag, input logic [6:0] o, input logic b, input logic d,
                      input logic a, input logic e, input logic [1:0] s);
    sb.push_back({o, b, d, a, e, s});
    tags.push_back(tag);
  endtask

  task automatic push_run(input string tag, input logic [6:0] o);
    push(tag, o, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
  endtask

  task automatic push_idle(input string tag);
    push(tag, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic push_done(input string tag);
    push(tag, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
  endtask

  // Unstalled walk: each enabled channel, lowest first, for len+1 cycles.
  task automatic push_walk(input string tag, input logic [6:0] mask, input int len);
    logic [6:0] oh;
    for (int ch = 0; ch < 7; ch++) begin
      oh = 7'b0000001 << ch;
      if (mask[ch]) begin
        for (int k = 0; k <= len; k++) push_run(tag, oh);
      end
    end
  endtask

  task automatic tick();
    logic [12:0] obs;
    logic [12:0] exp_v;
    string       t;
    @(posedge CLOCK);
    #1;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      t     = tags.pop_front();
      obs   = {OUT, BUSY, DONE, ABORTED, ERR, STATE};
      n_cmp++;
      assert (obs === exp_v) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", t, obs, exp_v);
      end
    end
  endtask

  task automatic idle_inputs();
    RESET = 1'b0; START = 1'b0; STALL = 1'b0; ABORT = 1'b0;
    CMD = 7'h00; LEN = 8'h00;
`ifdef CTRL_FSM_SEQ_REPEAT_EN
    REPEAT = 1'b0;
`endif
  endtask

  task automatic report(input string name, input int cycles);
    $display("txn %-10s cycles=%0d compared=%0d mismatched=%0d", name, cycles, n_cmp, n_mis);
  endtask

  initial begin
    int c;
    idle_inputs();

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      RESET = 1'b1; START = 1'($urandom); STALL = 1'($urandom); ABORT = 1'($urandom);
      CMD = 7'($urandom); LEN = 8'($urandom);
      push_idle("reset");
      tick();
    end
    idle_inputs();
    push_idle("post_reset");
    tick();
    report("reset", 3);

    // Basic walk; CMD/LEN scrambled during RUN, START during DONE ignored.
    push_walk("walk", 7'b0010101, 2);
    push_done("walk_done");
    push_idle("walk_idle");
    push_idle("start_in_done");
    c = 0;
    while (sb.size() > 0) begin
      START = (c == 0) || (c == 10);
      CMD   = (c == 0) ? 7'b0010101 : ((c == 10) ? 7'h7F : 7'($urandom));
      LEN   = (c == 0) ? 8'd2 : 8'($urandom);
      tick();
      c++;
    end
    idle_inputs();
    report("walk", c);

    // Stall in cycles 5-8, stray START during RUN.
    repeat (3) push_run("stall", 7'h01);
    repeat (7) push_run("stall", 7'h04);
    repeat (3) push_run("stall", 7'h10);
    push_done("stall_done");
    push_idle("stall_idle");
    c = 0;
    while (sb.size() > 0) begin
      START = (c == 0) || (c == 2);
      STALL = (c >= 5) && (c <= 8);
      CMD   = 7'b0010101;
      LEN   = 8'd2;
      tick();
      c++;
    end
    idle_inputs();
    report("stall", c);

    // Abort together with stall in cycle 5; ABORT in IDLE has no effect.
    repeat (3) push_run("abort", 7'h01);
    repeat (2) push_run("abort", 7'h04);
    push("abort_pulse", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    repeat (4) push_idle("abort_idle");
    c = 0;
    while (sb.size() > 0) begin
      START = (c == 0);
      ABORT = (c == 5) || (c == 8);
      STALL = (c == 5);
      CMD   = 7'b0010101;
      LEN   = 8'd2;
      tick();
      c++;
    end
    idle_inputs();
    report("abort", c);

    // START with empty mask.
    push("err_pulse", 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push_idle("err_idle");
    c = 0;
    while (sb.size() > 0) begin
      START = (c == 0);
      ABORT = (c == 1);
      CMD   = 7'h00;
      LEN   = 8'($urandom);
      tick();
      c++;
    end
    idle_inputs();
    report("err", c);

    // All channels, LEN=0.
    push_walk("full", 7'h7F, 0);
    push_done("full_done");
    push_idle("full_idle");
    c = 0;
    while (sb.size() > 0) begin
      START = (c == 0);
      CMD   = 7'h7F;
      LEN   = 8'd0;
      tick();
      c++;
    end
    idle_inputs();
    report("full", c);

    // Reset mid-run in cycle 3.
    repeat (3) push_run("mid_reset", 7'h01);
    repeat (2) push_idle("mid_reset_idle");
    c = 0;
    while (sb.size() > 0) begin
      START = (c == 0);
      RESET = (c == 3);
      CMD   = 7'b0010101;
      LEN   = 8'd2;
      tick();
      c++;
    end
    idle_inputs();
    report("mid_reset", c);

    // Maximum LEN on the highest channel.
    push_walk("maxlen", 7'h40, 255);
    push_done("maxlen_done");
    push_idle("maxlen_idle");
    c = 0;
    while (sb.size() > 0) begin
      START = (c == 0);
      CMD   = 7'h40;
      LEN   = 8'd255;
      tick();
      c++;
    end
    idle_inputs();
    report("maxlen", c);

`ifdef CTRL_FSM_SEQ_REPEAT_EN
    // Three passes over channels 0/1, REPEAT dropped before the last one ends.
    repeat (3) begin
      push_run("repeat", 7'h01);
      push_run("repeat", 7'h02);
    end
    push_done("repeat_done");
    push_idle("repeat_idle");
    c = 0;
    while (sb.size() > 0) begin
      START  = (c == 0);
      REPEAT = (c <= 4);
      CMD    = 7'h03;
      LEN    = 8'd0;
      tick();
      c++;
    end
    n_cmp++;
    assert (PASS_CNT === 8'd3) else begin
      n_mis++;
      $error("FAIL pass_cnt: observed %0d expected %0d", PASS_CNT, 3);
    end
    idle_inputs();
    report("repeat", c);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_seq.md
Name: ctrl_fsm_seq

Overview:
Parametrised sequencing controller, successor to the fixed 6-flop gate-level benchmark controllers in the benchmark set. It accepts a command mask and a phase length, then walks a one-hot strobe across the enabled output channels. Each enabled channel is held for a programmable number of cycles. Used as a generic, scalable FSM benchmark and testbench target, sized by parameters instead of hand netlists.

Parameters:
NCH, 7, number of output channels (>=2)
CNT_W, 8, phase timer width; LEN range 0..2^CNT_W-1

Ports:
CLOCK  input  1  single clock, rising-edge
RESET  input  1  synchronous, active-high reset
START  input  1  request a sequence; sampled only in IDLE
CMD  input  NCH  channel enable mask, latched on accepted START
LEN  input  CNT_W  phase length; each channel is active LEN+1 cycles; latched on accepted START
STALL  input  1  freeze timer and channel pointer while in RUN
ABORT  input  1  terminate the sequence from RUN
OUT  output  NCH  one-hot channel strobe (registered)
BUSY  output  1  high in RUN
DONE  output  1  one-cycle pulse on normal completion
ABORTED  output  1  one-cycle pulse after an abort
ERR  output  1  one-cycle pulse when START is given with CMD==0
STATE  output  2  IDLE=0, RUN=1, DONE=2; 3 is unused and recovers to IDLE

Behaviour:
- All outputs are registered. RESET is synchronous, active-high, and has priority over all other inputs.
- Reset values: OUT=0, BUSY=0, DONE=0, ABORTED=0, ERR=0, STATE=IDLE. The latched mask, timer and pointer are all cleared.
- Channel pointer width is $clog2(NCH). "Next channel" means the lowest set bit of the latched mask above the current pointer (combinational priority encoder).
- IDLE, START=1, CMD!=0: latch CMD and LEN; pointer = lowest set bit; timer = LEN; go to RUN. In the next cycle OUT=onehot(pointer) and BUSY=1. Latency from START to OUT is 1 cycle.
- IDLE, START=1, CMD==0: stay in IDLE; ERR=1 for the next cycle only.
- RUN, STALL=0, timer!=0: decrement the timer.
- RUN, STALL=0, timer==0, a next channel exists: move pointer to that channel; reload timer to LEN.
- RUN, STALL=0, timer==0, no next channel: go to DONE. OUT=0, BUSY=0, DONE=1 for that cycle.
- RUN, STALL=1: timer, pointer and OUT hold; BUSY stays 1.
- DONE: always returns to IDLE after 1 cycle. A START asserted during DONE is ignored.
- ABORT in RUN: next cycle STATE=IDLE, OUT=0, BUSY=0, ABORTED=1 for 1 cycle, DONE stays 0.
- ABORT has priority over STALL and over timer expiry. ABORT in IDLE or DONE has no effect.
- START while in RUN or DONE is ignored; CMD and LEN changes during RUN are ignored.
- Total RUN length = popcount(mask) × (LEN+1) + total stalled cycles.
- The timer never wraps: it is reloaded at 0 and never decremented below 0.
- RESET mid-RUN: the next cycle shows the reset values; no DONE or ABORTED pulse is produced.

Optional Feature:
CTRL_FSM_SEQ_REPEAT_EN
- Defined: adds input REPEAT (1 bit) and output PASS_CNT (8 bits, reset 0).
  - At the end of the last channel with REPEAT=1, the pointer wraps to the lowest set bit and the timer reloads to LEN. There is no DONE or IDLE gap between passes.
  - PASS_CNT increments on every completed pass, including the final one, and saturates at 255.
  - PASS_CNT clears on an accepted START and on RESET.
- Undefined: neither port exists, and the last channel always goes to DONE.

Test Plan:
- RESET=1 for 2 cycles with random inputs -> OUT=0, BUSY=0, DONE=0, ERR=0, STATE=0.
- CMD=7'b0010101, LEN=2, START pulse at cycle 0 -> OUT=7'h01 in cycles 1-3, 7'h04 in cycles 4-6, 7'h10 in cycles 7-9; DONE=1 and STATE=2 in cycle 10; STATE=0 in cycle 11.
- Same command with STALL=1 in cycles 5-8 -> 7'h04 held in cycles 4-10, 7'h10 in cycles 11-13, DONE in cycle 14.
- Same command with ABORT=1 in cycle 5 (together with STALL=1) -> cycle 6: OUT=0, STATE=0, ABORTED=1; DONE never asserts.
- START with CMD=0 -> ERR=1 for 1 cycle, STATE stays 0. Then CMD=7'h7F, LEN=0 -> OUT walks 7'h01..7'h40 over cycles 1-7, DONE in cycle 8.
- RESET=1 in cycle 3 of the LEN=2 run -> cycle 4 shows all-zero outputs. With CTRL_FSM_SEQ_REPEAT_EN, CMD=7'h03, LEN=0, REPEAT=1 for 3 passes then 0 -> OUT alternates 01/02 for 6 cycles, DONE in cycle 7, PASS_CNT=3.
